neuron_mac_ctrl: RTL
====================

Name: neuron_mac_ctrl

Overview:
Sequencer for one neuron's multiply-accumulate pass.
- On start, it walks N_INPUTS operand addresses and drives the read strobe.
- It tracks valid data through the fixed-latency pipelined multiplier, gates the accumulator enable, fires the activation stage once, then holds the result with a valid/ready handshake.
- Sits between the weight/input buffers, the Xilinx multiplier core, the accumulator and the activation unit.

Parameters:
N_INPUTS, 8, number of products per pass (>=1)
MUL_LAT, 3, multiplier pipeline latency in cycles (>=1)
IDX_W, 3, address width; must be >= ceil(log2(N_INPUTS)), minimum 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  begin pass; sampled only in IDLE
out_ready  in  1  downstream accepts the result
busy  out  1  high whenever state != IDLE
rd_en  out  1  operand buffer read strobe
rd_addr  out  IDX_W  operand index, 0..N_INPUTS-1
mul_vld  out  1  operands at multiplier input valid (rd_en delayed 1 cycle)
acc_clr  out  1  one-cycle accumulator clear
acc_en  out  1  accumulate multiplier output this cycle
act_en  out  1  one-cycle activation-stage enable
out_valid  out  1  result held stable for downstream

Behaviour:
- Reset (rst=1, asynchronous, active-high; clock clk): state=IDLE, index=0, delay line cleared. All outputs 0, including rd_addr.
- Reset mid-pass aborts immediately. In-flight products are discarded; no acc_en, act_en or out_valid follows.
- States: IDLE, ISSUE, DRAIN, ACT, HOLD.
- IDLE: start=1 -> ISSUE. start while not IDLE is ignored, with no queuing.
- ISSUE: rd_en=1 and rd_addr=index every cycle. index increments from 0 to N_INPUTS-1. On the last index -> DRAIN. index returns to 0, with no wrap past N_INPUTS-1.
- acc_clr=1 in the first ISSUE cycle only.
- mul_vld is rd_en registered once.
- acc_en is mul_vld delayed exactly MUL_LAT cycles.
- DRAIN: rd_en=0. Stay until the delay line holds no valid bit and acc_en for the last product has fired; then -> ACT.
- ACT: act_en=1 for exactly one cycle -> HOLD.
- HOLD: out_valid=1. On out_valid & out_ready -> IDLE, with out_valid low the next cycle. The earliest next start is accepted in that IDLE cycle.
- Timing, with start high in cycle 0:
  - rd_en cycles 1..N_INPUTS
  - mul_vld cycles 2..N_INPUTS+1
  - acc_en cycles 2+MUL_LAT..N_INPUTS+1+MUL_LAT
  - act_en cycle N_INPUTS+2+MUL_LAT
  - out_valid from cycle N_INPUTS+3+MUL_LAT
- Exactly N_INPUTS acc_en pulses and one act_en per pass.
- N_INPUTS=1: a single ISSUE cycle; acc_clr and rd_en coincide.
- out_ready held high continuously: HOLD lasts exactly 1 cycle.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.

Decomposition:
- Package nn_ctrl_pkg: state encoding constants (IDLE..HOLD) and the clog2 helper for deriving IDX_W.
- One sub-module, valid_delay_line: a parameterised DEPTH-stage shift register with the same asynchronous reset. It is instantiated with DEPTH=MUL_LAT to turn mul_vld into acc_en, and exposes an any_valid flag used by DRAIN.

Test Plan:
- Default N=8, L=3, out_ready=1, start pulse in cycle 0 -> rd_addr 0..7 in cycles 1..8; acc_en cycles 5..12 (8 pulses); act_en cycle 13; out_valid only cycle 14; busy cycles 1..14.
- out_ready=0 until cycle 20 -> out_valid stays 1 in cycles 14..20; IDLE in cycle 21; start in cycle 21 accepted, with acc_clr in cycle 22.
- start held high for the whole pass -> ignored while busy; a new pass begins only after the HOLD handshake.
- rst asserted in cycle 6 mid-ISSUE -> all outputs 0 immediately; no acc_en/act_en afterwards; a fresh start restarts at rd_addr=0.
- N_INPUTS=1, MUL_LAT=1, start in cycle 0 -> rd_en and acc_clr cycle 1; mul_vld cycle 2; acc_en cycle 3; act_en cycle 4; out_valid cycle 5.
- Random out_ready and start over 1000 passes -> acc_en count=N_INPUTS per act_en; rd_addr never exceeds N_INPUTS-1.

Source files
------------

// File: rtl/nn_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nn_ctrl_pkg : shared state encoding and width helper for the MAC      |
// | sequencer.  Rev 1.0                                                   |
// +----------------------------------------------------------------------+
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    ACT   = 3'd3,
    HOLD  = 3'd4
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/valid_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | valid_delay_line : DEPTH-stage valid shift register with pending flag |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module valid_delay_line #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  output logic vld_dly,
  output logic any_valid
);

  logic [DEPTH-1:0] stages;

  // any_valid flags a bit that has not yet reached the output stage,
  // so a consumer can leave its wait state in the cycle the last bit emerges.
  if (DEPTH == 1) begin : g_single
    always_ff @(posedge clk or posedge rst) begin
      if (rst) stages <= '0;
      else     stages <= vld;
    end
    assign any_valid = vld;
  end else begin : g_multi
    always_ff @(posedge clk or posedge rst) begin
      if (rst) stages <= '0;
      else     stages <= {stages[DEPTH-2:0], vld};
    end
    assign any_valid = vld | (|stages[DEPTH-2:0]);
  end

  assign vld_dly = stages[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/neuron_mac_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | neuron_mac_ctrl : sequences one neuron's multiply-accumulate pass     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module neuron_mac_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int N_INPUTS = 8,
  parameter int MUL_LAT  = 3,
  parameter int IDX_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             out_ready,
  output logic             busy,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_addr,
  output logic             mul_vld,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             act_en,
  output logic             out_valid
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  if (IDX_W < 1 || IDX_W < clog2(N_INPUTS) || N_INPUTS < 1 || MUL_LAT < 1) begin : g_param_check
    $error("neuron_mac_ctrl: illegal N_INPUTS/MUL_LAT/IDX_W combination");
  end

  state_t           state, state_nxt;
  logic [IDX_W-1:0] index, index_nxt;
  logic             mul_vld_q;
  logic             pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      index     <= '0;
      mul_vld_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      index     <= index_nxt;
      mul_vld_q <= (state == ISSUE);
    end
  end

  always_comb begin
    state_nxt = state;
    index_nxt = index;
    busy      = 1'b1;
    rd_en     = 1'b0;
    acc_clr   = 1'b0;
    act_en    = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        rd_en   = 1'b1;
        acc_clr = (index == '0);
        if (index == LAST_IDX) begin
          index_nxt = '0;
          state_nxt = DRAIN;
        end else begin
          index_nxt = index + 1'b1;
        end
      end
      // Leave in the cycle the last product's acc_en fires, so ACT follows it directly.
      DRAIN: begin
        if (!mul_vld_q && !pending) state_nxt = ACT;
      end
      ACT: begin
        act_en    = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  valid_delay_line #(
    .DEPTH (MUL_LAT)
  ) u_mul_track (
    .clk       (clk),
    .rst       (rst),
    .vld       (mul_vld_q),
    .vld_dly   (acc_en),
    .any_valid (pending)
  );

  assign rd_addr = index;
  assign mul_vld = mul_vld_q;

endmodule
`default_nettype wire
